// File: rtl/logicnet_pkg.sv
// Purpose: shared declarations for the LogicNets neuron sequencer slice.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
// Contents: sequencer FSM state enum and the LUT address-width helper.
package logicnet_pkg;

    // Sequencer states: idle/configurable, issuing reads, flushing the read pipe, holding result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } seq_state_t;

    // LUT address is {neuron_idx, in_bits}.
    function automatic int calc_addr_w(input int num_neurons, input int in_w);
        return $clog2(num_neurons) + in_w;
    endfunction

endpackage

// File: rtl/logicnet_neuron_sequencer_if.sv
// Purpose: handshake, result and configuration bundle for the neuron sequencer.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the vector side, out_valid/out_ready on the result side.
// Ports: master = upstream router / downstream layer / config agent; slave = sequencer.
//   in_valid, in_ready, in_vec    : input vector handshake, neuron k at in_vec[k*IN_W +: IN_W]
//   out_valid, out_ready, out_vec : result handshake, neuron k at out_vec[k*OUT_W +: OUT_W]
//   cfg_we, cfg_addr, cfg_data    : truth-table write port, cfg_addr = {neuron_idx, in_bits}
//   cfg_err                       : one-cycle pulse per rejected write
//   busy                          : sequencer is not idle
interface logicnet_neuron_sequencer_if #(
    parameter int NUM_NEURONS = 8,
    parameter int IN_W        = 4,
    parameter int OUT_W       = 2,
    parameter int ADDR_W      = logicnet_pkg::calc_addr_w(NUM_NEURONS, IN_W)
);
    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_NEURONS*IN_W-1:0]  in_vec;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_NEURONS*OUT_W-1:0] out_vec;
    logic                         cfg_we;
    logic [ADDR_W-1:0]            cfg_addr;
    logic [OUT_W-1:0]             cfg_data;
    logic                         cfg_err;
    logic                         busy;

    modport master (
        output in_valid, in_vec, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_vec, cfg_err, busy
    );

    modport slave (
        input  in_valid, in_vec, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_vec, cfg_err, busy
    );

endinterface

// File: rtl/logicnet_lut_ram.sv
// Purpose: shared truth-table store, one write port and one synchronous read port, no reset.
// Latency: read data valid one cycle after raddr is sampled.
// Backpressure: none; the sequencer never overlaps writes with its read sweep.
// Ports: clk; we/waddr/wdata write side; raddr/rdata read side.
module logicnet_lut_ram
    import logicnet_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents survive reset: truth tables are loaded once and reused across resets.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/logicnet_neuron_sequencer.sv
// Purpose: evaluates one LogicNets layer serially through a shared runtime-writable LUT.
// Latency: out_valid rises NUM_NEURONS+2 cycles after the accepting edge.
// Backpressure: one transaction at a time; result held until out_ready, then idle for one cycle.
// Ports: clk, rst (async active-high); bus = logicnet_neuron_sequencer_if.slave
//   (vector in, result out, truth-table configuration, cfg_err pulse, busy).
module logicnet_neuron_sequencer
    import logicnet_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int IN_W        = 4,
    parameter int OUT_W       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    logicnet_neuron_sequencer_if.slave  bus
);

    localparam int ADDR_W = calc_addr_w(NUM_NEURONS, IN_W);
    localparam int IDX_W  = $clog2(NUM_NEURONS);
    localparam int DEPTH  = NUM_NEURONS * (2 ** IN_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;

    logic [IDX_W-1:0]  idx;
    logic [IN_W-1:0]   vec_q  [NUM_NEURONS];
    logic [OUT_W-1:0]  slot_q [NUM_NEURONS];

    // Two-stage read pipe: rd_* = address registered into the LUT, dat_* = LUT data now on rdata.
    logic              rd_vld;
    logic [IDX_W-1:0]  rd_slot;
    logic [ADDR_W-1:0] rd_addr;
    logic              dat_vld;
    logic [IDX_W-1:0]  dat_slot;
    logic [OUT_W-1:0]  lut_rdata;

    logic              accept;
    logic              issue;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              busy_c;

    logic [31:0]       cfg_nidx;
    logic              cfg_in_range;
    logic              cfg_wr_ok;
    logic              cfg_err_q;
    logic [NUM_NEURONS*OUT_W-1:0] out_vec_c;

    // ------------------------------------------------------------------
    // Configuration arbitration: writes only land while idle and in range.
    // ------------------------------------------------------------------
    assign cfg_nidx     = 32'(bus.cfg_addr[ADDR_W-1:IN_W]);
    assign cfg_in_range = (cfg_nidx < 32'(NUM_NEURONS));
    assign cfg_wr_ok    = bus.cfg_we && (state == IDLE) && cfg_in_range;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        issue       = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                busy_c     = 1'b0;
                // A config write in the same cycle wins over a new vector.
                in_ready_c = !bus.cfg_we;
                if (bus.in_valid && !bus.cfg_we) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the last neuron's data is being written into its slot.
                if (dat_vld && (dat_slot == LAST_IDX)) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: index counter, read pipe, result slots, cfg_err pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            rd_vld    <= 1'b0;
            rd_slot   <= '0;
            rd_addr   <= '0;
            dat_vld   <= 1'b0;
            dat_slot  <= '0;
            cfg_err_q <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            cfg_err_q <= bus.cfg_we && !cfg_wr_ok;
            rd_vld    <= issue;
            dat_vld   <= rd_vld;
            dat_slot  <= rd_slot;
            if (accept) begin
                idx <= '0;
            end else if (issue) begin
                rd_slot <= idx;
                rd_addr <= {idx, vec_q[idx]};
                // Explicit wrap keeps idx in range for non-power-of-two neuron counts.
                idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            if (dat_vld) begin
                slot_q[dat_slot] <= lut_rdata;
            end
        end
    end

    // Captured vector: only sampled at acceptance, so upstream may change in_vec freely afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                vec_q[k] <= bus.in_vec[k*IN_W +: IN_W];
            end
        end
    end

    always_comb begin
        out_vec_c = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            out_vec_c[k*OUT_W +: OUT_W] = slot_q[k];
        end
    end

    logicnet_lut_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (OUT_W)
    ) u_lut (
        .clk   (clk),
        .we    (cfg_wr_ok),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (rd_addr),
        .rdata (lut_rdata)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_vec   = out_vec_c;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.busy      = busy_c;

endmodule
